// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel arbitrated mux with registered valid/ready output
// Round-robin or fixed-priority grant selects one producer per cycle into a single output register.

module rr_arb_mux_grant #(
  parameter int N_CH = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             mode,
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [N_CH-1:0] upper_mask;
  logic [N_CH-1:0] upper_req;

  function automatic logic [SEL_W-1:0] lowest(input logic [N_CH-1:0] v);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // Round-robin: prefer requests at or above ptr, otherwise wrap to the lowest request.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      upper_mask[i] = (SEL_W'(i) >= ptr);
    end
  end

  assign upper_req = req & upper_mask;
  assign found     = |req;

  always_comb begin
    idx = '0;
    if (mode || (upper_req == '0)) begin
      idx = lowest(req);
    end else begin
      idx = lowest(upper_req);
    end
  end

endmodule

module rr_arb_mux #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_found;
  logic             load_en;
  logic             accept;
  logic [SEL_W-1:0] next_ptr;
  logic [WIDTH-1:0] ch_data [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_split
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_arb_mux_grant #(
    .N_CH (N_CH)
  ) u_grant (
    .mode  (mode),
    .req   (in_valid),
    .ptr   (rr_ptr),
    .found (grant_found),
    .idx   (grant_idx)
  );

  assign load_en  = !out_valid || out_ready;
  // rst_n gates accept so no producer sees in_ready while the block is held in reset.
  assign accept   = rst_n && load_en && grant_found;
  assign next_ptr = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[grant_idx];
      out_ch    <= grant_idx;
      if (!mode) rr_ptr <= next_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
